// File: rtl/usb3_scram_ctrl_pkg.sv
// usb3_scram_ctrl_pkg: symbol constants and load-source encoding for the scrambler control stage
package usb3_scram_ctrl_pkg;
    localparam logic [7:0]  K28_5_COM = 8'hBC;
    localparam logic [7:0]  K28_1_SKP = 8'h3C;
    localparam logic [31:0] SKP_WORD  = {4{K28_1_SKP}};
    localparam logic [31:0] IDLE_WORD = 32'h0000_0000;
    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_DATA,
        SRC_SKP
    } src_e;
endpackage

// File: rtl/usb3_scram_ctrl_if.sv
// usb3_scram_ctrl_if: link-layer word handshake plus LFSR control and byte-mux outputs
interface usb3_scram_ctrl_if;
    logic [31:0] in_data;
    logic [3:0]  in_k;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] scram_data;
    logic        scram_en;
    logic        scram_rst;
    logic [31:0] mux_raw;
    logic [3:0]  mux_sel;
    logic [3:0]  mux_k;
    logic        mux_valid;
    modport slave (
        input  in_data, in_k, in_valid,
        output in_ready, scram_data, scram_en, scram_rst, mux_raw, mux_sel, mux_k, mux_valid
    );
    modport master (
        output in_data, in_k, in_valid,
        input  in_ready, scram_data, scram_en, scram_rst, mux_raw, mux_sel, mux_k, mux_valid
    );
endinterface

// File: rtl/usb3_scram_ctrl.sv
// usb3_scram_ctrl: loads one word per clock (SKP > upstream > idle) for the TX LFSR and
// delays raw data, K flags and bypass mask one stage to line up with the LFSR output.
module usb3_scram_ctrl
    import usb3_scram_ctrl_pkg::*;
#(
    parameter int SKP_INTERVAL = 88
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_scram_dis,
    usb3_scram_ctrl_if.slave  bus,
    output logic [9:0]        skp_count
);
    src_e        src;
    logic [31:0] ld_data;
    logic [3:0]  ld_k;
    logic [9:0]  cnt_inc;
    logic        skp_due;
    logic        skp_due_nxt;
    logic        a_valid;
    logic [3:0]  a_k;
    logic [3:0]  a_sel;

    always_comb begin
        src         = skp_due ? SRC_SKP : bus.in_valid ? SRC_DATA : SRC_IDLE;
        ld_data     = src == SRC_SKP ? SKP_WORD : src == SRC_DATA ? bus.in_data : IDLE_WORD;
        ld_k        = src == SRC_SKP ? 4'hF : src == SRC_DATA ? bus.in_k : 4'h0;
        cnt_inc     = skp_count + 10'd1;
        skp_due_nxt = !skp_due && cnt_inc == 10'(SKP_INTERVAL);
    end

    // SKP bytes are K28.1, never K28.5, so the COM test needs no SKP exclusion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.scram_data <= '0;
            bus.scram_en   <= 1'b0;
            bus.scram_rst  <= 1'b0;
            a_k            <= '0;
            a_sel          <= '0;
            a_valid        <= 1'b0;
            bus.mux_raw    <= '0;
            bus.mux_k      <= '0;
            bus.mux_sel    <= '0;
            bus.mux_valid  <= 1'b0;
            skp_count      <= '0;
            skp_due        <= 1'b0;
            bus.in_ready   <= 1'b1;
        end else begin
            bus.scram_data <= ld_data;
            bus.scram_en   <= src != SRC_SKP;
            bus.scram_rst  <= ld_k[0] && ld_data[7:0] == K28_5_COM;
            a_k            <= ld_k;
            a_sel          <= (src == SRC_SKP || cfg_scram_dis) ? 4'hF : ld_k;
            a_valid        <= 1'b1;
            bus.mux_raw    <= bus.scram_data;
            bus.mux_k      <= a_k;
            bus.mux_sel    <= a_sel;
            bus.mux_valid  <= a_valid;
            skp_count      <= skp_due ? 10'd0 : cnt_inc;
            skp_due        <= skp_due_nxt;
            bus.in_ready   <= !skp_due_nxt;
        end
    end
endmodule

// File: tb/tb_usb3_scram_ctrl.sv
// tb_usb3_scram_ctrl: randomized and directed checks of the scrambler control stage
// against a word-stream reference model and a behavioural LFSR.
module tb_usb3_scram_ctrl;
    localparam int SKP = 4;
    localparam logic [31:0] SKPW = 32'h3C3C3C3C;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic cfg_scram_dis = 1'b0;
    logic [9:0] skp_count;
    usb3_scram_ctrl_if bus();

    usb3_scram_ctrl #(.SKP_INTERVAL(SKP)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cfg_scram_dis(cfg_scram_dis),
        .bus(bus),
        .skp_count(skp_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;

    // reference model: loaded word (m_*), word one stage older (b_*), data words since last SKP
    logic [31:0] m_data, b_raw;
    logic [3:0]  m_k, m_sel, b_k, b_sel;
    logic        m_en, m_rst, m_v, b_v, m_rdy, last_acc;
    int          n;

    logic [85:0] obs;
    assign obs = {bus.scram_data, bus.scram_en, bus.scram_rst, bus.mux_raw, bus.mux_sel,
                  bus.mux_k, bus.mux_valid, bus.in_ready, skp_count};

    function automatic logic [85:0] mdl();
        return {m_data, m_en, m_rst, b_raw, b_sel, b_k, b_v, m_rdy, 10'(n)};
    endfunction

    // behavioural LFSR x^16+x^5+x^4+x^3+1, seeded 16'hFFFF, 32 shifts per enabled word
    logic [15:0] lfsr;
    int          adv_cnt;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] t = s;
        for (int b = 0; b < 32; b++) t = {t[14:0], 1'b0} ^ (t[15] ? 16'h0039 : 16'h0000);
        return t;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr    <= 16'hFFFF;
            adv_cnt <= 0;
        end else begin
            if (bus.scram_rst) lfsr <= 16'hFFFF;
            else if (bus.scram_en) lfsr <= lfsr_adv(lfsr);
            if (bus.scram_en) adv_cnt <= adv_cnt + 1;
        end
    end

    task automatic model_reset();
        m_data = '0; m_k = '0; m_sel = '0; m_en = 0; m_rst = 0; m_v = 0;
        b_raw = '0; b_k = '0; b_sel = '0; b_v = 0; m_rdy = 1; n = 0; last_acc = 0;
    endtask

    task automatic apply_reset();
        bus.in_valid = 0; bus.in_data = '0; bus.in_k = '0; cfg_scram_dis = 0;
        reset_n = 0;
        model_reset();
        @(posedge clock);
        #1 reset_n = 1;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic dis);
        logic skp;
        bus.in_valid = v; bus.in_data = d; bus.in_k = k; cfg_scram_dis = dis;
        @(posedge clock);
        skp = (n == SKP);
        last_acc = v && !skp;
        b_raw = m_data; b_k = m_k; b_sel = m_sel; b_v = m_v;
        if (skp) begin
            m_data = SKPW; m_k = 4'hF; m_en = 0; m_rst = 0; m_sel = 4'hF; n = 0;
        end else begin
            m_data = v ? d : 32'h0; m_k = v ? k : 4'h0; m_en = 1;
            m_rst = m_k[0] && m_data[7:0] == 8'hBC;
            m_sel = dis ? 4'hF : m_k; n++;
        end
        m_v = 1;
        m_rdy = (n != SKP);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== mdl()) begin fails++; $display("FAIL reset_state got %h want %h", obs, mdl()); end
        for (int i = 1; i <= 3; i++) begin
            step(0, 32'h0, 4'h0, 0);
            checks++;
            if (obs !== mdl()) begin fails++; $display("FAIL reset_idle cyc %0d got %h want %h", i, obs, mdl()); end
            checks++;
            if (bus.mux_valid !== (i >= 2)) begin
                fails++; $display("FAIL reset_mux_valid cyc %0d got %b want %b", i, bus.mux_valid, i >= 2);
            end
        end
    endtask

    task automatic test_interval();
        logic [31:0] w = 32'h100, nxt = 32'h100;
        int skps = 0, low = 0;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            step(1, w, 4'h0, 0);
            if (last_acc) w++;
            if (!bus.in_ready) low++;
            if (!bus.scram_en) skps++;
            else begin
                checks++;
                if (bus.scram_data !== nxt) begin fails++; $display("FAIL interval_order got %h want %h", bus.scram_data, nxt); end
                nxt++;
            end
            checks++;
            if (obs !== mdl()) begin fails++; $display("FAIL interval cyc %0d got %h want %h", i, obs, mdl()); end
        end
        checks++;
        if (skps != 6 || low != 6) begin fails++; $display("FAIL interval_counts skp %0d ready_low %0d want 6 6", skps, low); end
    endtask

    task automatic test_com();
        apply_reset();
        step(1, 32'hBCBCBCBC, 4'hF, 0);
        checks++;
        if (bus.scram_rst !== 1'b1 || obs !== mdl()) begin fails++; $display("FAIL com_rst got %h want %h", obs, mdl()); end
        step(1, 32'h0, 4'h0, 0);
        checks++;
        if (bus.mux_sel !== 4'hF || obs !== mdl()) begin fails++; $display("FAIL com_sel got %h want %h", obs, mdl()); end
        checks++;
        if (lfsr !== 16'hFFFF) begin fails++; $display("FAIL com_lfsr_init got %h want ffff", lfsr); end
        step(0, 32'h0, 4'h0, 0);
        checks++;
        if (lfsr !== lfsr_adv(16'hFFFF)) begin fails++; $display("FAIL com_lfsr_adv got %h want %h", lfsr, lfsr_adv(16'hFFFF)); end
    endtask

    task automatic test_scram_dis();
        logic [36:0] stim [12];
        int adv [2];
        for (int i = 0; i < 12; i++) stim[i] = {1'($urandom), 4'($urandom), ($urandom & 32'hFFFF_FF7F)};
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            for (int i = 0; i < 12; i++) begin
                step(stim[i][36], stim[i][31:0], stim[i][35:32], r[0]);
                checks++;
                if (obs !== mdl()) begin fails++; $display("FAIL scram_dis%0d cyc %0d got %h want %h", r, i, obs, mdl()); end
                if (r == 1 && bus.mux_valid) begin
                    checks++;
                    if (bus.mux_sel !== 4'hF) begin fails++; $display("FAIL scram_dis_sel got %h want f", bus.mux_sel); end
                end
            end
            adv[r] = adv_cnt;
        end
        checks++;
        if (adv[0] != 9 || adv[1] != 9) begin fails++; $display("FAIL scram_dis_adv got %0d %0d want 9 9", adv[0], adv[1]); end
    endtask

    task automatic test_com_on_skp();
        apply_reset();
        for (int i = 0; i < SKP; i++) step(1, $urandom & 32'hFFFF_FF00, 4'h0, 0);
        step(1, 32'hBCBCBCBC, 4'hF, 0);
        checks++;
        if (bus.scram_data !== SKPW || bus.scram_en !== 1'b0 || last_acc) begin
            fails++; $display("FAIL com_skp_first got %h en %b want %h en 0", bus.scram_data, bus.scram_en, SKPW);
        end
        step(1, 32'hBCBCBCBC, 4'hF, 0);
        checks++;
        if (bus.scram_rst !== 1'b1 || skp_count !== 10'd1 || obs !== mdl()) begin
            fails++; $display("FAIL com_skp_then_com got %h want %h", obs, mdl());
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'($urandom), $urandom, 4'($urandom), 0);
        checks++;
        if (skp_count !== 10'd3) begin fails++; $display("FAIL mid_pre_count got %0d want 3", skp_count); end
        #2 reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== mdl()) begin fails++; $display("FAIL mid_reset_async got %h want %h", obs, mdl()); end
        @(posedge clock);
        #1 reset_n = 1;
        for (int i = 1; i <= SKP + 1; i++) begin
            step(1'($urandom), $urandom & 32'hFFFF_FF00, 4'($urandom), 0);
            checks++;
            if (obs !== mdl() || (bus.scram_en === 1'b0) != (i == SKP + 1)) begin
                fails++; $display("FAIL mid_reset_run load %0d got %h want %h", i, obs, mdl());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_interval();
        test_com();
        test_scram_dis();
        test_com_on_skp();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
